pipelined_adder: RTL and testbench

//   Parametrised, pipelined WIDTH-bit adder/subtractor built from full-adder carry chains.

---
 rtl/pipelined_adder_pkg.sv | 19 +
 rtl/pipelined_adder_if.sv | 35 +++
 rtl/pipelined_adder_stage.sv | 104 ++++++++++
 rtl/pipelined_adder.sv | 78 +++++++
 tb/tb_pipelined_adder.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_adder_pkg.sv
// Shared sizing helpers for the pipelined adder/subtractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 32;
    localparam int DEFAULT_STAGES = 4;

    // Bits resolved per pipeline stage.
    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

    // Legal geometry: at least one stage, no more stages than bits, equal chunks.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for the pipelined adder; master = producer/consumer side.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the operand and the result side.
// Signal ovf exists only when PIPELINED_ADDER_OVF_EN is defined.
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;

    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, ovf);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, ovf);
`else
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout);
`endif

endinterface

// File: rtl/pipelined_adder_stage.sv
// One pipeline stage: CHUNK-bit ripple add of chunk IDX plus its payload register.
// Latency: 1 cycle.
// Backpressure: holds while valid and downstream not ready; accepts when empty or draining.
// Ports: in_* = payload from the previous stage, dn_rdy = downstream ready, out_* = registered payload.
// out_ovf (PIPELINED_ADDER_OVF_EN only) = carry into chunk MSB xor carry out of chunk MSB.
module pipelined_adder_stage
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_vld,
    input  logic             dn_rdy,
    input  logic             in_carry,
    input  logic [WIDTH-1:0] in_acc,
    input  logic [WIDTH-1:0] in_opb,
    output logic             out_vld,
    output logic             out_carry,
    output logic [WIDTH-1:0] out_acc,
`ifdef PIPELINED_ADDER_OVF_EN
    output logic             out_ovf,
`endif
    output logic [WIDTH-1:0] out_opb
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);
    localparam int LO    = IDX * CHUNK;

    // acc holds resolved sum chunks below this stage and raw operand A above it,
    // so the upper operand bits and the lower result bits share one register.
    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] opb;
`ifdef PIPELINED_ADDER_OVF_EN
        logic             ovf;
`endif
    } payload_t;

    logic             vld_q;
    logic             take;
    payload_t         pay_q;
    payload_t         pay_d;
    logic             c_rip;
    logic [CHUNK-1:0] s_rip;
    logic [CHUNK-1:0] x_rip;
    logic [CHUNK-1:0] y_rip;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             c_top;
`endif

    assign take = in_vld && (!vld_q || dn_rdy);

    always_comb begin
        pay_d = '0;
        x_rip = in_acc[LO +: CHUNK];
        y_rip = in_opb[LO +: CHUNK];
        c_rip = in_carry;
        s_rip = '0;
`ifdef PIPELINED_ADDER_OVF_EN
        c_top = in_carry;
`endif
        for (int i = 0; i < CHUNK; i++) begin
`ifdef PIPELINED_ADDER_OVF_EN
            c_top = c_rip;
`endif
            s_rip[i] = x_rip[i] ^ y_rip[i] ^ c_rip;
            c_rip    = (x_rip[i] & y_rip[i]) | (c_rip & (x_rip[i] ^ y_rip[i]));
        end
        pay_d.carry            = c_rip;
        pay_d.acc              = in_acc;
        pay_d.acc[LO +: CHUNK] = s_rip;
        pay_d.opb              = in_opb;
`ifdef PIPELINED_ADDER_OVF_EN
        pay_d.ovf              = c_top ^ c_rip;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            pay_q <= '0;
        end else begin
            if (!vld_q || dn_rdy) begin
                vld_q <= in_vld;
            end
            if (take) begin
                pay_q <= pay_d;
            end
        end
    end

    assign out_vld   = vld_q;
    assign out_carry = pay_q.carry;
    assign out_acc   = pay_q.acc;
    assign out_opb   = pay_q.opb;
`ifdef PIPELINED_ADDER_OVF_EN
    assign out_ovf   = pay_q.ovf;
`endif

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor, carry rippling one CHUNK per stage, 1 result/cycle.
// Latency: STAGES cycles from accept to out_valid when not stalled.
// Backpressure: elastic valid/ready; bubbles collapse, in_ready low only when full and out_ready low.
// Ports: clk, rst_n (async active-low), bus (slave modport): in_valid/in_ready/a/b/cin/sub,
//   out_valid/out_ready/sum/cout, plus ovf when PIPELINED_ADDER_OVF_EN is defined.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    pipelined_adder_if.slave  bus
);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    // v[k] is the valid entering stage k; v[STAGES] is out_valid.
    logic [STAGES:0]  v;
    logic [STAGES:0]  rdy;
    logic             carry_s [STAGES+1];
    logic [WIDTH-1:0] acc_s   [STAGES+1];
    logic [WIDTH-1:0] opb_s   [STAGES+1];
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf_s   [STAGES];
`endif

    // Subtraction is a + ~b + ~cin; a borrow-in becomes a missing carry-in.
    assign v[0]       = bus.in_valid;
    assign acc_s[0]   = bus.a;
    assign opb_s[0]   = bus.sub ? ~bus.b : bus.b;
    assign carry_s[0] = bus.sub ? ~bus.cin : bus.cin;

    // Ready chain unrolled from the stage valids only, so it never feeds back on itself:
    // stage k can take a beat if any stage at or after k is empty, or the consumer is taking.
    always_comb begin
        rdy         = '0;
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = rdy[k+1] | ~v[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        pipelined_adder_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_vld    (v[k]),
            .dn_rdy    (rdy[k+1]),
            .in_carry  (carry_s[k]),
            .in_acc    (acc_s[k]),
            .in_opb    (opb_s[k]),
            .out_vld   (v[k+1]),
            .out_carry (carry_s[k+1]),
            .out_acc   (acc_s[k+1]),
`ifdef PIPELINED_ADDER_OVF_EN
            .out_ovf   (ovf_s[k]),
`endif
            .out_opb   (opb_s[k+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = v[STAGES];
    assign bus.sum       = acc_s[STAGES];
    assign bus.cout      = carry_s[STAGES];
`ifdef PIPELINED_ADDER_OVF_EN
    assign bus.ovf       = ovf_s[STAGES-1];
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at STAGES = 1, 4 and 32 (WIDTH = 32), scoreboard-checked.
// Latency: n/a.
// Backpressure: drives random and directed out_ready stalls.
module tb_pipelined_adder;

    localparam int W  = 32;
    localparam int ND = 3;
    localparam int DIR = 1;   // index of the STAGES=4 instance used by the directed steps
`ifdef PIPELINED_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         drv_valid  [ND];
    logic         drv_cin    [ND];
    logic         drv_sub    [ND];
    logic         drv_oready [ND];
    logic [W-1:0] drv_a      [ND];
    logic [W-1:0] drv_b      [ND];
    wire          obs_iready [ND];
    wire          obs_ovalid [ND];
    wire          obs_cout   [ND];
    wire          obs_ovf    [ND];
    wire  [W-1:0] obs_sum    [ND];

    for (genvar i = 0; i < ND; i++) begin : g_dut
        localparam int ST = (i == 0) ? 1 : ((i == 1) ? 4 : 32);
        pipelined_adder_if #(.WIDTH(W)) bus ();
        pipelined_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
        assign bus.in_valid  = drv_valid[i];
        assign bus.a         = drv_a[i];
        assign bus.b         = drv_b[i];
        assign bus.cin       = drv_cin[i];
        assign bus.sub       = drv_sub[i];
        assign bus.out_ready = drv_oready[i];
        assign obs_iready[i] = bus.in_ready;
        assign obs_ovalid[i] = bus.out_valid;
        assign obs_cout[i]   = bus.cout;
        assign obs_sum[i]    = bus.sum;
`ifdef PIPELINED_ADDER_OVF_EN
        assign obs_ovf[i]    = bus.ovf;
`else
        assign obs_ovf[i]    = 1'b0;
`endif
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [33:0] sbq0 [$];
    logic [33:0] sbq1 [$];
    logic [33:0] sbq2 [$];
    logic        accepted [ND];
    int          acc_cnt  [ND];
    logic        held_vld [ND];
    logic [33:0] held_val [ND];

    // Reference: {ovf, cout, sum} of a + b + cin or a - b - cin.
    function automatic logic [33:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input logic sub);
        logic [32:0] r;
        logic        ovf;
        if (!sub) begin
            r   = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            ovf = (a[31] == b[31]) && (r[31] != a[31]);
        end else begin
            r   = {1'b0, a} + {1'b0, ~b} + {32'd0, ~cin};
            ovf = (a[31] != b[31]) && (r[31] != a[31]);
        end
        return {ovf & OVF_ON, r};
    endfunction

    function automatic logic [33:0] obs_word(input int d);
        return {obs_ovf[d], obs_cout[d], obs_sum[d]};
    endfunction

    function automatic int sb_size(input int d);
        case (d)
            0:       return sbq0.size();
            1:       return sbq1.size();
            default: return sbq2.size();
        endcase
    endfunction

    task automatic sb_push(input int d, input logic [33:0] v);
        case (d)
            0:       sbq0.push_back(v);
            1:       sbq1.push_back(v);
            default: sbq2.push_back(v);
        endcase
    endtask

    task automatic sb_pop(input int d, output logic [33:0] v);
        case (d)
            0:       v = sbq0.pop_front();
            1:       v = sbq1.pop_front();
            default: v = sbq2.pop_front();
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: evaluate handshakes with settled inputs, then advance to the next falling edge.
    task automatic tick();
        logic [33:0] e;
        #1;
        for (int d = 0; d < ND; d++) begin
            accepted[d] = rst_n && drv_valid[d] && obs_iready[d];
            if (accepted[d]) begin
                sb_push(d, model(drv_a[d], drv_b[d], drv_cin[d], drv_sub[d]));
                acc_cnt[d]++;
            end
            if (held_vld[d]) begin
                check($sformatf("stall_hold_d%0d", d), {obs_ovalid[d], obs_word(d)}, {1'b1, held_val[d]});
            end
            held_vld[d] = obs_ovalid[d] && !drv_oready[d];
            held_val[d] = obs_word(d);
            if (obs_ovalid[d] && drv_oready[d]) begin
                check($sformatf("sb_has_entry_d%0d", d), 64'(sb_size(d) != 0), 64'd1);
                if (sb_size(d) != 0) begin
                    sb_pop(d, e);
                    check($sformatf("sb_result_d%0d", d), obs_word(d), e);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_sb();
        sbq0.delete();
        sbq1.delete();
        sbq2.delete();
        for (int d = 0; d < ND; d++) begin
            held_vld[d] = 1'b0;
            accepted[d] = 1'b0;
        end
    endtask

    // Single beat on the STAGES=4 instance, no stall; checks latency and the constant result.
    task automatic run_beat(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input logic [W-1:0] esum,
                            input logic ecout, input logic eovf);
        int n;
        drv_a[DIR] = a; drv_b[DIR] = b; drv_cin[DIR] = cin; drv_sub[DIR] = sub;
        drv_valid[DIR] = 1'b1; drv_oready[DIR] = 1'b1;
        tick();
        drv_valid[DIR] = 1'b0;
        n = 1;
        while (!obs_ovalid[DIR] && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_sum"}, 64'(obs_sum[DIR]), 64'(esum));
        check({tag, "_cout"}, 64'(obs_cout[DIR]), 64'(ecout));
        if (OVF_ON) begin
            check({tag, "_ovf"}, 64'(obs_ovf[DIR]), 64'(eovf));
        end
        tick();
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] corners [4];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h7FFF_FFFF;
        corners[3] = 32'h8000_0000;
        if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 3)];
        return $urandom;
    endfunction

    initial begin
        int first, cnt, last, base, seen;
        for (int d = 0; d < ND; d++) begin
            drv_valid[d] = 1'b0; drv_a[d] = '0; drv_b[d] = '0;
            drv_cin[d] = 1'b0; drv_sub[d] = 1'b0; drv_oready[d] = 1'b0;
            acc_cnt[d] = 0;
        end
        clear_sb();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state on every instance.
        for (int d = 0; d < ND; d++) begin
            check($sformatf("rst_out_valid_d%0d", d), 64'(obs_ovalid[d]), 64'd0);
            check($sformatf("rst_sum_d%0d", d), 64'(obs_sum[d]), 64'd0);
            check($sformatf("rst_cout_d%0d", d), 64'(obs_cout[d]), 64'd0);
            check($sformatf("rst_in_ready_d%0d", d), 64'(obs_iready[d]), 64'd1);
        end
        rst_n = 1'b1;
        for (int d = 0; d < ND; d++) drv_oready[d] = 1'b1;
        tick();

        // Carry across every chunk, subtract with borrow, signed overflow.
        run_beat("t1_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_beat("t2_sub", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_beat("t2_ovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_beat("t2_subcin", 32'd10, 32'd3, 1'b1, 1'b1, 32'd6, 1'b1, 1'b0);

        // Eight back-to-back beats, consumer always ready.
        first = -1; cnt = 0; last = -1;
        for (int i = 0; i < 16; i++) begin
            drv_valid[DIR] = (i < 8);
            drv_a[DIR] = 32'h1111_1111 * i; drv_b[DIR] = ~(32'h0101_0101 * i);
            drv_cin[DIR] = i[0]; drv_sub[DIR] = i[1];
            if (obs_ovalid[DIR]) begin
                if (first < 0) first = i;
                cnt++;
                last = i;
            end
            tick();
        end
        check("t3_first_out", 64'(first), 64'd4);
        check("t3_count", 64'(cnt), 64'd8);
        check("t3_last_out", 64'(last), 64'd11);

        // Stall: consumer not ready for six cycles while the producer keeps offering.
        base = acc_cnt[DIR];
        drv_oready[DIR] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0 || accepted[DIR]) begin
                drv_a[DIR] = $urandom; drv_b[DIR] = $urandom;
                drv_cin[DIR] = 1'($urandom_range(0, 1)); drv_sub[DIR] = 1'($urandom_range(0, 1));
            end
            drv_valid[DIR] = 1'b1;
            #1;
            check($sformatf("t4_in_ready_%0d", i), 64'(obs_iready[DIR]), 64'(i < 4));
            tick();
        end
        check("t4_accepts", 64'(acc_cnt[DIR] - base), 64'd4);
        drv_valid[DIR] = 1'b0;
        drv_oready[DIR] = 1'b1;
        repeat (8) tick();
        check("t4_drained", 64'(sb_size(DIR)), 64'd0);

        // Reset with three beats in flight.
        drv_oready[DIR] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv_a[DIR] = 32'h0100 + i; drv_b[DIR] = 32'h20; drv_cin[DIR] = 1'b0; drv_sub[DIR] = 1'b0;
            drv_valid[DIR] = 1'b1;
            tick();
        end
        drv_valid[DIR] = 1'b0;
        tick();
        check("t5_pre_out_valid", 64'(obs_ovalid[DIR]), 64'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_out_valid", 64'(obs_ovalid[DIR]), 64'd0);
        check("t5_rst_sum", 64'(obs_sum[DIR]), 64'd0);
        check("t5_rst_cout", 64'(obs_cout[DIR]), 64'd0);
        clear_sb();
        @(negedge clk);
        rst_n = 1'b1;
        drv_oready[DIR] = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (obs_ovalid[DIR]) seen++;
            tick();
        end
        check("t5_no_stale_out", 64'(seen), 64'd0);
        run_beat("t5_new", 32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0);

        // Random traffic on all three geometries with random stalls.
        for (int d = 0; d < ND; d++) begin
            accepted[d] = 1'b0;
            drv_valid[d] = 1'b0;
        end
        for (int it = 0; it < 600; it++) begin
            for (int d = 0; d < ND; d++) begin
                if (!drv_valid[d] || accepted[d]) begin
                    drv_valid[d] = ($urandom_range(0, 3) != 0);
                    drv_a[d] = pick(); drv_b[d] = pick();
                    drv_cin[d] = 1'($urandom_range(0, 1)); drv_sub[d] = 1'($urandom_range(0, 1));
                end
                drv_oready[d] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end
        for (int d = 0; d < ND; d++) begin
            drv_valid[d] = 1'b0;
            drv_oready[d] = 1'b1;
        end
        repeat (40) tick();
        for (int d = 0; d < ND; d++) begin
            check($sformatf("t6_drained_d%0d", d), 64'(sb_size(d)), 64'd0);
            check($sformatf("t6_traffic_d%0d", d), 64'(acc_cnt[d] > 100), 64'd1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
